// File: rtl/signed_division_unit.sv
// Multi-cycle signed divider (restoring, one quotient bit per clock) with C truncation semantics.
// Latency WIDTH+1 edges from accept to done (1 edge for divide-by-zero); start ignored while busy.
module signed_division_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dzf_q, dzf_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dzf_d   = dzf_q;
    ovf_d   = ovf_q;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial without loss.
    trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    abs1  = inp1[WIDTH-1] ? -inp1 : inp1;
    abs2  = inp2[WIDTH-1] ? -inp2 : inp2;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = abs1;
          dvs_d   = abs2;
          nq_d    = inp1[WIDTH-1] ^ inp2[WIDTH-1];
          nr_d    = inp1[WIDTH-1];
          count_d = '0;
          busy_d  = 1'b1;
          dz_d    = (inp2 == '0);
          ov_d    = (inp1 == MIN_VAL) && (inp2 == '1);
          // Divide-by-zero skips the loop; preloading |inp1| lets SIGN rebuild inp1 as the remainder.
          rem_d   = (inp2 == '0) ? abs1 : '0;
          state_d = (inp2 == '0) ? S_SIGN : S_RUN;
        end
      end
      S_RUN: begin
        dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
        count_d = count_q + CW'(1);
        if (count_q == LAST_CNT) state_d = S_SIGN;
      end
      S_SIGN: begin
        quo_d   = dz_q ? '1 : (nq_q ? -dvd_q : dvd_q);
        rmd_d   = nr_q ? -rem_q : rem_q;
        dzf_d   = dz_q;
        ovf_d   = ov_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dzf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dzf_q   <= dzf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dzf_q;
  assign overflow  = ovf_q;

endmodule
